// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: first-word-fall-through byte buffer between the UART RX deserializer and the MMIO peripheral.
// Define UART_RX_RTS_EN to add the uart_rts_n hysteresis flow-control output.
module uart_rx_fifo #(
    parameter int DEPTH      = 16,
    parameter int ADDR_W     = $clog2(DEPTH),
    parameter int HIGH_WATER = DEPTH - 4,
    parameter int LOW_WATER  = DEPTH / 4
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic [7:0]      rx_data,
    input  logic            rx_valid,
    output logic [7:0]      uart_rx_data,
    input  logic            uart_rx_rd_en,
    output logic            uart_rx_empty,
    output logic            uart_rx_full,
    output logic [ADDR_W:0] rx_level,
    output logic            rx_overflow,
`ifdef UART_RX_RTS_EN
    output logic            uart_rts_n,
`endif
    input  logic            clr_overflow
);

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

    logic [7:0]        r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic              r_overflow;

    logic              w_pop;
    logic              w_wr;
    logic              w_ovf_ev;
    logic [ADDR_W:0]   w_count_nxt;

    generate
        if ((1 << ADDR_W) != DEPTH || DEPTH < 4 || DEPTH > 256) begin : g_bad_depth
            $error("uart_rx_fifo: DEPTH must be a power of two in 4..256");
        end
    endgenerate

    // A pop in the same cycle frees a slot, so a full buffer still accepts the write.
    always_comb begin
        w_pop       = uart_rx_rd_en && (r_count != '0);
        w_wr        = rx_valid && ((r_count != DEPTH_C) || w_pop);
        w_ovf_ev    = rx_valid && (r_count == DEPTH_C) && !w_pop;
        w_count_nxt = r_count;
        if (w_wr && !w_pop) begin
            w_count_nxt = r_count + 1'b1;
        end else if (!w_wr && w_pop) begin
            w_count_nxt = r_count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= w_count_nxt;
            if (clr_overflow) begin
                r_overflow <= 1'b0;
            end
            if (w_ovf_ev) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Storage is deliberately not cleared by reset; the pointers make stale bytes unreachable.
    always_ff @(posedge clk) begin
        if (resetn && w_wr) begin
            r_mem[r_wr_ptr] <= rx_data;
        end
    end

    assign uart_rx_data  = (r_count == '0) ? 8'h00 : r_mem[r_rd_ptr];
    assign uart_rx_empty = (r_count == '0);
    assign uart_rx_full  = (r_count == DEPTH_C);
    assign rx_level      = r_count;
    assign rx_overflow   = r_overflow;

`ifdef UART_RX_RTS_EN
    localparam logic [ADDR_W:0] HIGH_C = (ADDR_W + 1)'(HIGH_WATER);
    localparam logic [ADDR_W:0] LOW_C  = (ADDR_W + 1)'(LOW_WATER);

    logic r_rts_n;

    generate
        if (!(LOW_WATER < HIGH_WATER && HIGH_WATER <= DEPTH)) begin : g_bad_water
            $error("uart_rx_fifo: need LOW_WATER < HIGH_WATER <= DEPTH");
        end
    endgenerate

    // Hysteresis on the post-update level: stop the sender near full, release once mostly drained.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_rts_n <= 1'b0;
        end else if (w_count_nxt >= HIGH_C) begin
            r_rts_n <= 1'b1;
        end else if (w_count_nxt <= LOW_C) begin
            r_rts_n <= 1'b0;
        end
    end

    assign uart_rts_n = r_rts_n;
`else
    generate
        if (HIGH_WATER < 0 || LOW_WATER < 0) begin : g_bad_water
            $error("uart_rx_fifo: water marks must be non-negative");
        end
    endgenerate
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: vector table, hand-written corner sequences and a
// randomized run against a queue-based reference model.
module tb_uart_rx_fifo;

    localparam int DEPTH = 16;
    localparam int HW    = 12;
    localparam int LW    = 4;

    logic       clk;
    logic       resetn;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] uart_rx_data;
    logic       uart_rx_rd_en;
    logic       uart_rx_empty;
    logic       uart_rx_full;
    logic [4:0] rx_level;
    logic       rx_overflow;
    logic       clr_overflow;
`ifdef UART_RX_RTS_EN
    logic       uart_rts_n;
`endif

    uart_rx_fifo #(.DEPTH(DEPTH)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .uart_rx_data  (uart_rx_data),
        .uart_rx_rd_en (uart_rx_rd_en),
        .uart_rx_empty (uart_rx_empty),
        .uart_rx_full  (uart_rx_full),
        .rx_level      (rx_level),
        .rx_overflow   (rx_overflow),
`ifdef UART_RX_RTS_EN
        .uart_rts_n    (uart_rts_n),
`endif
        .clr_overflow  (clr_overflow)
    );

    // ---------------- clock / reset defaults ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        resetn        = 1'b0;
        rx_data       = 8'h00;
        rx_valid      = 1'b0;
        uart_rx_rd_en = 1'b0;
        clr_overflow  = 1'b0;
    end

    // ---------------- reference model and scoreboard ----------------
    logic [7:0] model_q[$];
    logic       m_ovf;
    logic       m_rts;
    logic [7:0] exp_q[$];
    int         checks;
    int         errors;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input logic rst_n, input logic v, input logic [7:0] d,
                              input logic rd, input logic clr);
        bit pop;
        bit ovf_ev;
        if (!rst_n) begin
            model_q.delete();
            m_ovf = 1'b0;
            m_rts = 1'b0;
            return;
        end
        pop    = rd && (model_q.size() > 0);
        ovf_ev = v && (model_q.size() == DEPTH) && !pop;
        if (pop) void'(model_q.pop_front());
        if (v && !ovf_ev) model_q.push_back(d);
        if (clr) m_ovf = 1'b0;
        if (ovf_ev) m_ovf = 1'b1;
        if (model_q.size() >= HW) m_rts = 1'b1;
        else if (model_q.size() <= LW) m_rts = 1'b0;
    endtask

    task automatic check_model(input string tag);
        logic [7:0] e_data;
        e_data = (model_q.size() > 0) ? model_q[0] : 8'h00;
        chk({tag, "_empty"}, 32'(uart_rx_empty), 32'(model_q.size() == 0));
        chk({tag, "_full"},  32'(uart_rx_full),  32'(model_q.size() == DEPTH));
        chk({tag, "_level"}, 32'(rx_level),      32'(model_q.size()));
        chk({tag, "_data"},  32'(uart_rx_data),  32'(e_data));
        chk({tag, "_ovf"},   32'(rx_overflow),   32'(m_ovf));
`ifdef UART_RX_RTS_EN
        chk({tag, "_rts"},   32'(uart_rts_n),    32'(m_rts));
`endif
    endtask

    // ---------------- driver ----------------
    // Called #1 after an edge: drives inputs, waits one edge, samples #1 later.
    task automatic apply_cycle(input logic rst_n, input logic v, input logic [7:0] d,
                               input logic rd, input logic clr, input string tag);
        resetn        = rst_n;
        rx_valid      = v;
        rx_data       = d;
        uart_rx_rd_en = rd;
        clr_overflow  = clr;
        @(posedge clk);
        #1;
        model_step(rst_n, v, d, rd, clr);
        check_model(tag);
    endtask

    task automatic do_reset();
        apply_cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, "rst");
        apply_cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, "rst");
    endtask

    task automatic fill_seq(input int n);
        for (int i = 0; i < n; i++) begin
            apply_cycle(1'b1, 1'b1, 8'(i), 1'b0, 1'b0, "fill");
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic       rst_n;
        logic       v;
        logic [7:0] d;
        logic       rd;
        logic       clr;
        logic       e_empty;
        logic       e_full;
        logic [4:0] e_level;
        logic [7:0] e_data;
        logic       e_ovf;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic rst_n, input logic v, input logic [7:0] d,
                                input logic rd, input logic clr, input logic e_empty,
                                input logic e_full, input logic [4:0] e_level,
                                input logic [7:0] e_data, input logic e_ovf);
        vec_t r;
        r.rst_n = rst_n; r.v = v; r.d = d; r.rd = rd; r.clr = clr;
        r.e_empty = e_empty; r.e_full = e_full; r.e_level = e_level;
        r.e_data = e_data; r.e_ovf = e_ovf;
        return r;
    endfunction

    initial begin
        checks = 0;
        errors = 0;
        m_ovf  = 1'b0;
        m_rts  = 1'b0;

        //          rst v  d      rd clr empty full lvl data   ovf
        tbl.push_back(mk(1, 1, 8'h41, 0, 0, 0, 0, 5'd1, 8'h41, 0));
        tbl.push_back(mk(1, 1, 8'h42, 0, 0, 0, 0, 5'd2, 8'h41, 0));
        tbl.push_back(mk(1, 1, 8'h43, 0, 0, 0, 0, 5'd3, 8'h41, 0));
        tbl.push_back(mk(1, 0, 8'h00, 1, 0, 0, 0, 5'd2, 8'h42, 0));
        tbl.push_back(mk(1, 0, 8'h00, 1, 0, 0, 0, 5'd1, 8'h43, 0));
        tbl.push_back(mk(1, 0, 8'h00, 1, 0, 1, 0, 5'd0, 8'h00, 0));
        tbl.push_back(mk(1, 0, 8'h00, 1, 0, 1, 0, 5'd0, 8'h00, 0));
        tbl.push_back(mk(1, 1, 8'h7E, 1, 0, 0, 0, 5'd1, 8'h7E, 0));
        tbl.push_back(mk(1, 1, 8'h11, 0, 0, 0, 0, 5'd2, 8'h7E, 0));
        tbl.push_back(mk(0, 1, 8'h99, 1, 0, 1, 0, 5'd0, 8'h00, 0));
        tbl.push_back(mk(1, 0, 8'h00, 0, 0, 1, 0, 5'd0, 8'h00, 0));

        #1;
        do_reset();
        chk("reset_empty", 32'(uart_rx_empty), 32'd1);
        chk("reset_full",  32'(uart_rx_full),  32'd0);
        chk("reset_level", 32'(rx_level),      32'd0);
        chk("reset_data",  32'(uart_rx_data),  32'h00);
        chk("reset_ovf",   32'(rx_overflow),   32'd0);

        foreach (tbl[i]) begin
            apply_cycle(tbl[i].rst_n, tbl[i].v, tbl[i].d, tbl[i].rd, tbl[i].clr, "tblm");
            chk($sformatf("tbl%0d_empty", i), 32'(uart_rx_empty), 32'(tbl[i].e_empty));
            chk($sformatf("tbl%0d_full", i),  32'(uart_rx_full),  32'(tbl[i].e_full));
            chk($sformatf("tbl%0d_level", i), 32'(rx_level),      32'(tbl[i].e_level));
            chk($sformatf("tbl%0d_data", i),  32'(uart_rx_data),  32'(tbl[i].e_data));
            chk($sformatf("tbl%0d_ovf", i),   32'(rx_overflow),   32'(tbl[i].e_ovf));
        end

        // Fill, overflow, set-beats-clear, drain, clear.
        do_reset();
        fill_seq(16);
        chk("fill_full",  32'(uart_rx_full), 32'd1);
        chk("fill_level", 32'(rx_level),     32'd16);
        apply_cycle(1'b1, 1'b1, 8'hAA, 1'b0, 1'b0, "ovf");
        chk("ovf_set",   32'(rx_overflow), 32'd1);
        chk("ovf_level", 32'(rx_level),    32'd16);
        apply_cycle(1'b1, 1'b1, 8'hBB, 1'b0, 1'b1, "ovfclr");
        chk("ovf_set_wins", 32'(rx_overflow), 32'd1);
        for (int i = 0; i < 16; i++) begin
            chk("drain_data", 32'(uart_rx_data), 32'(i));
            apply_cycle(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, "drain");
        end
        chk("drain_empty", 32'(uart_rx_empty), 32'd1);
        apply_cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, "clr");
        chk("ovf_cleared", 32'(rx_overflow), 32'd0);

        // Full with simultaneous write and pop.
        do_reset();
        fill_seq(16);
        apply_cycle(1'b1, 1'b1, 8'h55, 1'b1, 1'b0, "fullwp");
        chk("fullwp_level", 32'(rx_level),     32'd16);
        chk("fullwp_ovf",   32'(rx_overflow),  32'd0);
        chk("fullwp_head",  32'(uart_rx_data), 32'h01);
        for (int i = 1; i < 16; i++) begin
            chk("fullwp_data", 32'(uart_rx_data), 32'(i));
            apply_cycle(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, "fullwp_drain");
        end
        chk("fullwp_last", 32'(uart_rx_data), 32'h55);
        apply_cycle(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, "fullwp_drain");
        chk("fullwp_empty", 32'(uart_rx_empty), 32'd1);

        // Wrap-around stream: 40 bytes, a pop every second cycle, scoreboard on popped bytes.
        begin
            int sent;
            int got;
            sent = 0;
            got  = 0;
            exp_q.delete();
            do_reset();
            for (int k = 0; k < 200 && got < 40; k++) begin
                logic       v;
                logic       rd;
                logic [7:0] d;
                v  = (sent < 40) && (k % 3 != 2);
                rd = (k % 2 == 1);
                d  = 8'($urandom_range(0, 255));
                if (rd && exp_q.size() > 0) begin
                    chk("wrap_data", 32'(uart_rx_data), 32'(exp_q.pop_front()));
                    got++;
                end
                if (v) begin
                    exp_q.push_back(d);
                    sent++;
                end
                apply_cycle(1'b1, v, d, rd, 1'b0, "wrap");
            end
            chk("wrap_count", 32'(got), 32'd40);
            chk("wrap_empty", 32'(uart_rx_empty), 32'd1);
            chk("wrap_noovf", 32'(rx_overflow), 32'd0);
        end

`ifdef UART_RX_RTS_EN
        // RTS hysteresis and mid-stream reset.
        do_reset();
        fill_seq(11);
        chk("rts_11", 32'(uart_rts_n), 32'd0);
        apply_cycle(1'b1, 1'b1, 8'h0B, 1'b0, 1'b0, "rts");
        chk("rts_12", 32'(uart_rts_n), 32'd1);
        for (int i = 0; i < 7; i++) begin
            apply_cycle(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, "rts_pop");
        end
        chk("rts_lvl5_level", 32'(rx_level), 32'd5);
        chk("rts_lvl5", 32'(uart_rts_n), 32'd1);
        apply_cycle(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, "rts_pop");
        chk("rts_lvl4", 32'(uart_rts_n), 32'd0);
        fill_seq(10);
        chk("rts_refill", 32'(uart_rts_n), 32'd1);
        apply_cycle(1'b0, 1'b1, 8'hEE, 1'b1, 1'b1, "rts_rst");
        chk("rts_rst_rts",   32'(uart_rts_n),    32'd0);
        chk("rts_rst_empty", 32'(uart_rx_empty), 32'd1);
        chk("rts_rst_level", 32'(rx_level),      32'd0);
`endif

        // Randomized traffic with alternating fill-heavy and drain-heavy phases.
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            logic fill_phase;
            logic rst_n;
            logic v;
            logic rd;
            logic clr;
            fill_phase = ((k / 150) % 2 == 0);
            rst_n = ($urandom_range(0, 499) != 0);
            v     = fill_phase ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 9) < 3);
            rd    = fill_phase ? ($urandom_range(0, 9) < 2) : ($urandom_range(0, 9) < 7);
            clr   = ($urandom_range(0, 19) == 0);
            apply_cycle(rst_n, v, 8'($urandom_range(0, 255)), rd, clr, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
